// File: rtl/prio_encoder_8to3_hs.sv
// prio_encoder_8to3_hs: clocked 8-to-3 priority encoder.
// Active-low request lines are synchronized and falling-edge detected, then latched
// into pending bits. The highest pending index is presented with a valid/ack handshake.
// 74148-style EI/EO/GS pins let two blocks cascade into a 16-line encoder.
module prio_encoder_8to3_hs #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_n_i,
    input  logic       ei_n_i,
    input  logic       ack_i,
    output logic [2:0] code_o,
    output logic       valid_o,
    output logic       gs_n_o,
    output logic       eo_n_o,
    output logic [7:0] pending_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  prev_q;
    logic [7:0]                  pending_q, pending_d;
    logic [7:0]                  synced;
    logic [7:0]                  fall;
    logic [7:0]                  clr;
    logic [2:0]                  code_q, code_d;

    if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 1..4");
    end

    // Index of the highest set bit; bit 7 has the highest priority.
    function automatic logic [2:0] highest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Synchronizer shift: stage 0 captures the raw lines, each later stage copies its predecessor.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = req_n_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Falling-edge detect and pending update; a set and a clear on the same bit keeps it set.
    always_comb begin
        synced    = sync_q[SYNC_STAGES-1];
        fall      = prev_q & ~synced;
        clr       = (state_q == PRESENT && ack_i) ? (8'h01 << code_q) : 8'h00;
        pending_d = (pending_q & ~clr) | fall;
    end

    // Request path registers; synchronizers reset high so a line held low yields one edge at release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '1;
            prev_q    <= 8'hFF;
            pending_q <= 8'h00;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= synced;
            pending_q <= pending_d;
        end
    end

    // FSM state and presented-code registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic; priority is resolved only when leaving IDLE.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (!ei_n_i && pending_q != 8'h00) begin
                    state_d = PRESENT;
                    code_d  = highest_idx(pending_q);
                end
            end
            PRESENT: begin
                if (ack_i) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; eo_n_o also follows ei_n_i combinationally.
    always_comb begin
        valid_o   = (state_q == PRESENT);
        gs_n_o    = ~(state_q == PRESENT);
        eo_n_o    = ~(!ei_n_i && pending_q == 8'h00 && state_q == IDLE);
        code_o    = code_q;
        pending_o = pending_q;
    end

endmodule

// File: doc/prio_encoder_8to3_hs.md
Name: prio_encoder_8to3_hs

Overview:
- Clocked 8-to-3 priority encoder with request latching and a valid/ack handshake. It is the encode-side counterpart of the 3-to-8 line decoder.
- Eight active-low request lines, e.g. decoder-style yn outputs, are synchronized and edge-detected.
- Each asserted line is held in a pending register.
- The highest-index pending line is presented as a 3-bit code until acknowledged.
- 74148-style EI/EO/GS pins allow cascading two blocks into a 16-line encoder.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per request line; legal range 1..4.

Ports:
clk_i  in  1  clock; all registers update on its rising edge
rst_i  in  1  reset, synchronous, active-high
req_n_i  in  8  request lines, active-low; asynchronous to clk_i
ei_n_i  in  1  enable input, active-low; gates presentation of new codes
ack_i  in  1  consumer acknowledge of the presented code
code_o  out  3  index of the presented request; 7 is the highest priority
valid_o  out  1  code_o is valid and held stable
gs_n_o  out  1  group select, active-low; always equal to ~valid_o
eo_n_o  out  1  enable output, active-low, for cascading
pending_o  out  8  pending request bits; bit i corresponds to req_n_i[i]

Behaviour:
- Reset (rst_i=1 at a clock edge) forces all of the following, and overrides any in-flight presentation:
  - state=IDLE
  - pending_o=8'h00
  - code_o=3'd0, valid_o=0, gs_n_o=1
  - all synchronizer flops and previous-value flops=8'hFF, so no spurious edge is detected at release
- Synchronizer: each line passes through a chain of SYNC_STAGES flops. The last stage is the synced value s[i]. A prev[i] flop holds s[i] from the previous cycle.
- Edge detect: a request is a falling edge, prev[i]=1 and s[i]=0. A line that is held low never re-requests.
- A line held low through reset produces exactly one edge after release.
- Latency:
  - Let E0 be the first clock edge at which req_n_i[i] samples low.
  - pending_o[i] goes to 1 at edge E0+SYNC_STAGES.
  - valid_o goes to 1 at edge E0+SYNC_STAGES+1 if the FSM is IDLE and ei_n_i=0.
- Pending set/clear:
  - A bit is set by an edge and cleared by acknowledge of that index.
  - A set and clear of the same bit in the same cycle leave the bit at 1 (set wins).
- FSM states:
  - IDLE: valid_o=0. Go to PRESENT when ei_n_i=0 and pending_o!=0. On that transition, register code_o = index of the highest set pending bit.
  - PRESENT: valid_o=1 and code_o is held constant. ei_n_i changes do not withdraw the code.
    - If ack_i=1: clear pending[code_o] and go to GAP.
    - If ack_i=0: stay in PRESENT.
  - GAP: valid_o=0 for exactly one cycle, then go to IDLE. ack_i is ignored here, so an ack held high consumes exactly one code per presentation.
- Timing consequence: minimum spacing between consecutive valid presentations is 3 cycles (PRESENT, GAP, IDLE).
- ack_i in IDLE or GAP has no effect.
- code_o keeps its last value while valid_o=0. Its value is meaningful only when valid_o=1.
- eo_n_o is combinational from registered state and ei_n_i. It is 0 only when ei_n_i=0, pending_o=0 and state=IDLE; otherwise 1.
- Cascade rule: eo_n_o of the high block drives ei_n_i of the low block.
- Priority is evaluated only at the IDLE to PRESENT transition. A higher request arriving during PRESENT waits for the next presentation.

Test Plan:
1. Reset and idle:
   - Stimulus: rst_i=1 for 2 cycles, req_n_i=8'hFF, ei_n_i=0.
   - Required: valid_o=0, gs_n_o=1, pending_o=8'h00, eo_n_o=0, code_o=0.
2. Single request:
   - Stimulus: drive req_n_i[5]=0 sampled at E0; ack_i=1 for one cycle while valid_o=1.
   - Required: pending_o=8'h20 at E0+2; valid_o=1 with code_o=5 at E0+3; after the ack, pending_o=8'h00 and valid_o=0 for at least 2 cycles.
3. Priority:
   - Stimulus: lines 2 and 6 fall on the same edge; ack each presentation.
   - Required: code_o=6 is presented first, then code_o=2; pending_o goes 8'h44, then 8'h04, then 8'h00.
4. Enable gating:
   - Stimulus: ei_n_i=1, line 3 falls.
   - Required: pending_o=8'h08, valid_o stays 0, eo_n_o=1. After ei_n_i=0, valid_o=1 with code_o=3 one cycle later.
5. Set-wins and ack held:
   - Stimulus: hold ack_i=1 continuously; a new edge on line 4 is timed to coincide with the ack of code 4.
   - Required: pending_o[4] stays 1 and code 4 is re-presented after GAP. Each presentation lasts exactly 1 cycle.
6. Reset mid-PRESENT and sweep:
   - Stimulus: assert rst_i while valid_o=1 with code 7.
   - Required: next edge gives valid_o=0 and pending_o=0.
   - Sweep: pulse each line 0..7 separately. Required: code_o equals the line index every time.
